// File: rtl/final_soc_pio_pkg.sv
// Shared definitions for the final_soc multi-channel output PIO bank.
// Optional macro FINAL_SOC_PIO_SETCLR_EN enables atomic set/clear writes on sel=3.
package final_soc_pio_pkg;

  localparam logic [1:0] SEL_SHADOW = 2'd0;
  localparam logic [1:0] SEL_LIVE   = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_SETCLR = 2'd3;

  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_MODE   = 1;
  localparam int unsigned CTRL_ABORT  = 2;
  localparam int unsigned CTRL_DONE   = 3;
  localparam int unsigned CTRL_IRQ_EN = 4;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } commit_state_t;

endpackage

// File: rtl/final_soc_pio_commit_fsm.sv
// Commit sequencer: frame_sync edge detect, IDLE/PENDING/APPLY FSM,
// DONE flag and registered interrupt.
module final_soc_pio_commit_fsm (
  input  logic clk,
  input  logic reset_n,
  input  logic commit,
  input  logic abort,
  input  logic mode,
  input  logic done_clr,
  input  logic irq_en,
  input  logic frame_sync,
  output logic apply,
  output logic pending,
  output logic done,
  output logic irq
);
  import final_soc_pio_pkg::*;

  commit_state_t state, state_nx;
  logic          sync_d;
  logic          sync_rise;
  logic          done_nx;

  assign sync_rise = frame_sync & ~sync_d;

  // Next-state and DONE computation; ABORT beats COMMIT, APPLY set beats W1C.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (commit && !abort) state_nx = mode ? APPLY : PENDING;
      PENDING: begin
        if (abort)          state_nx = IDLE;
        else if (sync_rise) state_nx = APPLY;
      end
      APPLY:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    done_nx = done;
    if (state == APPLY) done_nx = 1'b1;
    else if (done_clr)  done_nx = 1'b0;
  end

  // State register with registered status/interrupt outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sync_d  <= 1'b0;
      apply   <= 1'b0;
      pending <= 1'b0;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_nx;
      sync_d  <= frame_sync;
      apply   <= (state_nx == APPLY);
      pending <= (state_nx == PENDING);
      done    <= done_nx;
      irq     <= done_nx & irq_en;
    end
  end

endmodule

// File: rtl/final_soc_pio_bank.sv
// NUM_CH x WIDTH output PIO with shadow/live double buffering and an atomic
// commit on frame_sync or immediately. Avalon-MM slave, zero-latency reads.
// Optional macro FINAL_SOC_PIO_SETCLR_EN: sel=3 performs bit set/clear on shadow[ch].
module final_soc_pio_bank #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       WIDTH     = 10,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CH_W+1:0]         address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    frame_sync,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    irq
);
  import final_soc_pio_pkg::*;

  logic [1:0]       sel;
  logic [CH_W-1:0]  ch;
  logic             wr;
  logic             ctrl_wr;
  logic             mode_q, irq_en_q;
  logic             mode_nx, irq_en_nx;
  logic             apply, pending, done;
  logic [WIDTH-1:0] shadow [NUM_CH];
  logic [WIDTH-1:0] live   [NUM_CH];
  logic [WIDTH-1:0] shadow_sel, live_sel;
  logic             unused_wdata;

  assign sel       = address[CH_W+1:CH_W];
  assign ch        = address[CH_W-1:0];
  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (sel == SEL_CTRL);
  // The FSM must see mode/irq_en as they will be after the current write.
  assign mode_nx   = ctrl_wr ? writedata[CTRL_MODE]   : mode_q;
  assign irq_en_nx = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;
  assign unused_wdata = ^writedata;

  final_soc_pio_commit_fsm u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .commit     (ctrl_wr & writedata[CTRL_COMMIT]),
    .abort      (ctrl_wr & writedata[CTRL_ABORT]),
    .mode       (mode_nx),
    .done_clr   (ctrl_wr & writedata[CTRL_DONE]),
    .irq_en     (irq_en_nx),
    .frame_sync (frame_sync),
    .apply      (apply),
    .pending    (pending),
    .done       (done),
    .irq        (irq)
  );

  // CTRL mode and interrupt-enable bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      mode_q   <= mode_nx;
      irq_en_q <= irq_en_nx;
    end
  end

  // Shadow registers: CPU writes; out-of-range channels match no k and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) shadow[k] <= RESET_VAL;
    end else if (wr) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (32'(ch) == k) begin
          if (sel == SEL_SHADOW) shadow[k] <= writedata[WIDTH-1:0];
`ifdef FINAL_SOC_PIO_SETCLR_EN
          else if (sel == SEL_SETCLR)
            shadow[k] <= writedata[31] ? (shadow[k] & ~writedata[WIDTH-1:0])
                                       : (shadow[k] |  writedata[WIDTH-1:0]);
`endif
        end
      end
    end
  end

  // Live registers: all channels copy their shadow together on the apply pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) live[k] <= RESET_VAL;
    end else if (apply) begin
      for (int unsigned k = 0; k < NUM_CH; k++) live[k] <= shadow[k];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_port[g*WIDTH +: WIDTH] = live[g];
  end

  // Per-channel read selection; no match (out-of-range ch) yields zero.
  always_comb begin
    shadow_sel = '0;
    live_sel   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(ch) == k) begin
        shadow_sel = shadow[k];
        live_sel   = live[k];
      end
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    readdata = '0;
    case (sel)
      SEL_SHADOW: readdata[WIDTH-1:0] = shadow_sel;
      SEL_LIVE:   readdata[WIDTH-1:0] = live_sel;
      SEL_CTRL: begin
        readdata[CTRL_COMMIT] = pending;
        readdata[CTRL_MODE]   = mode_q;
        readdata[CTRL_DONE]   = done;
        readdata[CTRL_IRQ_EN] = irq_en_q;
      end
      default: begin
`ifdef FINAL_SOC_PIO_SETCLR_EN
        readdata[WIDTH-1:0] = shadow_sel;
`else
        readdata = '0;
`endif
      end
    endcase
  end

endmodule

// File: doc/final_soc_pio_bank.md
Name: final_soc_pio_bank

Overview:
- Parametrised successor to the single-channel Avalon-MM output PIO.
- NUM_CH independent WIDTH-bit output channels, each with a CPU-writable shadow register and a live register that drives out_port.
- Shadow-to-live transfer is atomic across all channels, either on the next frame_sync rising edge or immediately.
- Gives the NIOS software tear-free updates of VGA-facing parameters (sizes, positions) in the final_soc system.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- WIDTH, 10, bits per channel (1..31).
- RESET_VAL, 0, reset value of every shadow and live register (WIDTH bits).
- CH_W, localparam = max(1, clog2(NUM_CH)), channel-index width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  CH_W+2  {sel[1:0], ch[CH_W-1:0]}.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended, combinational.
- frame_sync  in  1  frame boundary level, already in the clk domain.
- out_port  out  NUM_CH*WIDTH  live registers; channel k at [k*WIDTH +: WIDTH].
- irq  out  1  commit-done interrupt.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset: all shadow and live registers = RESET_VAL; state IDLE; ctrl mode/irq_en = 0; done = 0; irq = 0; sync_d = 0.
- Write qualifier: wr = chipselect & ~write_n.
- Read path: readdata is combinational (zero wait states, read latency 0). Unused bits read 0. Reads have no side effects.
- Address map, by sel:
  - sel=0: shadow[ch], read/write. A write loads writedata[WIDTH-1:0].
  - sel=1: live[ch], read-only; writes are ignored.
  - sel=2: CTRL (ch ignored).
    - Write bit0 COMMIT, bit1 IMMEDIATE mode, bit2 ABORT, bit3 write-1-clear DONE, bit4 IRQ_EN.
    - Read bit0 PENDING, bit1 mode, bit3 DONE, bit4 IRQ_EN.
  - sel=3: reserved; reads 0, writes ignored (unless SETCLR_EN).
- Out-of-range channel (ch >= NUM_CH): reads 0, writes ignored.
- Edge detect: sync_d <= frame_sync; sync_rise = frame_sync & ~sync_d.
- FSM states IDLE, PENDING, APPLY.
  - IDLE: a CTRL write with bit0=1 and bit2=0 -> APPLY if mode=1 (after the same write), else PENDING.
  - PENDING: ABORT -> IDLE with no live change. sync_rise -> APPLY. A COMMIT while PENDING has no effect.
  - APPLY (one cycle): every live[k] <= shadow[k] as held at that edge; DONE <= 1; -> IDLE.
- Latency:
  - Immediate mode: live visible 2 cycles after the CTRL write edge.
  - Sync mode: live visible 2 cycles after frame_sync rises.
- Simultaneous events:
  - Shadow write in the APPLY cycle: live takes the old shadow value; the new value remains in shadow.
  - ABORT and COMMIT in the same write: ABORT wins.
  - sync_rise in the same cycle as the COMMIT write: not taken; waits for the next rising edge.
  - DONE set by APPLY and a W1C in the same cycle: set wins.
- Shadow writes during PENDING are allowed and are included in the commit.
- irq = DONE & IRQ_EN, registered-output equivalent (no combinational path from the bus).
- Reset asserted mid-PENDING or mid-APPLY: everything returns to reset values immediately; no partial commit is visible.

Optional Feature:
- Macro: FINAL_SOC_PIO_SETCLR_EN.
- Defined: sel=3 write performs an atomic bit set/clear on shadow[ch].
  - writedata[31]=0: shadow |= mask.
  - writedata[31]=1: shadow &= ~mask.
  - mask = writedata[WIDTH-1:0].
  - sel=3 reads return shadow[ch].
- Not defined: sel=3 is reserved as above.

Decomposition:
- Package final_soc_pio_pkg:
  - sel codes SEL_SHADOW/SEL_LIVE/SEL_CTRL/SEL_SETCLR.
  - CTRL bit-position constants.
  - commit_state_t enum {IDLE, PENDING, APPLY}.
- Sub-module final_soc_pio_commit_fsm: edge detect, FSM, DONE/irq logic.
  - Inputs: commit, abort, mode, done_clr, frame_sync.
  - Output: apply pulse.
  - The top level holds the register arrays and the bus decode.

Test Plan:
- Reset value: reset with RESET_VAL=0x155 -> out_port all channels 0x155, irq=0, CTRL reads 0.
- Sync-mode commit: write shadow[2]=0x3FF, CTRL=0x01 -> PENDING=1 and out_port ch2 unchanged. Raise frame_sync -> ch2=0x3FF two cycles later, DONE=1; W1C 0x08 -> DONE=0.
- Immediate mode and irq: CTRL=0x12 then CTRL=0x13 -> live updates 2 cycles later, irq=1. Write 0x1A (DONE W1C, mode and IRQ_EN kept) -> irq=0.
- Abort: commit pending, then CTRL=0x04 -> PENDING=0. frame_sync pulse -> live unchanged, DONE=0.
- Collision: shadow[0] write of 0x0AA in the APPLY cycle -> live[0] gets the old value, shadow[0] reads 0x0AA.
- SETCLR (macro on): shadow=0x0F0; sel3 write 0x00F -> 0x0FF; sel3 write 0x8000_00F0 -> 0x00F. Macro off: same writes ignored, reads 0.
